muldiv_seq: RTL

- Multi-cycle sequencer for the HI/LO arithmetic unit. Executes MULT, MULTU, DIV and DIVU issued from the E stage.
- Holds the pipeline with a stall request while the operation runs.
- Returns a 64-bit {hi,lo} result with a one-cycle ready strobe. The M-stage HI/LO write uses this result.
- Handles cancellation on exception flush. Contains a radix-2 restoring divider and a registered multiply path.

---
 rtl/muldiv_seq_pkg.sv | 13 +
 rtl/muldiv_seq_div_radix2_core.sv | 50 +++++
 rtl/muldiv_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - op and state encodings shared by the HI/LO sequencer
package muldiv_seq_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/muldiv_seq_div_radix2_core.sv
// rtl/muldiv_seq_div_radix2_core.sv - restoring radix-2 divider on magnitudes
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividendMag,
    input  logic [WIDTH-1:0] divisorMag,
    output logic [WIDTH-1:0] quoNext,
    output logic [WIDTH-1:0] remNext
);

    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;

    // quoNext/remNext are the result of the current step, so the owner can
    // capture the final iteration at the same edge that retires it.
    always_comb begin
        remShift = {remReg, quoReg[WIDTH-1]};
        diff     = remShift - {1'b0, divisorReg};
        if (!diff[WIDTH]) begin
            remNext = diff[WIDTH-1:0];
            quoNext = {quoReg[WIDTH-2:0], 1'b1};
        end else begin
            remNext = remShift[WIDTH-1:0];
            quoNext = {quoReg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
        end else if (load) begin
            remReg     <= '0;
            quoReg     <= dividendMag;
            divisorReg <= divisorMag;
        end else if (step) begin
            remReg <= remNext;
            quoReg <= quoNext;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with stall and ready strobe
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               divOp;
    logic               quoNeg;
    logic               remNeg;
    logic               divZero;
    logic [WIDTH-1:0]   srcAReg;
    logic [2*WIDTH-1:0] mulPipe [MUL_LAT];

    logic               issue;
    logic               lastStep;
    logic               isDiv;
    logic               signedOp;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [2*WIDTH-1:0] aExt;
    logic [2*WIDTH-1:0] bExt;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quoStep;
    logic [WIDTH-1:0]   remStep;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    assign isDiv    = (op == MD_DIV) || (op == MD_DIVU);
    assign signedOp = (op == MD_MULT) || (op == MD_DIV);
    assign aNeg     = signedOp && src_a[WIDTH-1];
    assign bNeg     = signedOp && src_b[WIDTH-1];
    assign aMag     = aNeg ? -src_a : src_a;
    assign bMag     = bNeg ? -src_b : src_b;
    assign aExt     = {{WIDTH{aNeg}}, src_a};
    assign bExt     = {{WIDTH{bNeg}}, src_b};
    assign product  = aExt * bExt;

    assign issue    = (state == ST_IDLE) && start && !cancel;
    assign lastStep = (state == ST_BUSY) && (count == CW'(1)) && !cancel;
    assign stall    = issue || ((state == ST_BUSY) && !cancel);
    assign ready    = (state == ST_DONE) && !cancel;

    div_radix2_core #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load       (issue && isDiv),
        .step       ((state == ST_BUSY) && divOp && !cancel),
        .dividendMag(aMag),
        .divisorMag (bMag),
        .quoNext    (quoStep),
        .remNext    (remStep)
    );

    assign quoFix = quoNeg ? -quoStep : quoStep;
    assign remFix = remNeg ? -remStep : remStep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            divOp   <= 1'b0;
            quoNeg  <= 1'b0;
            remNeg  <= 1'b0;
            divZero <= 1'b0;
            srcAReg <= '0;
        end else if (cancel) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state   <= ST_BUSY;
                    count   <= isDiv ? CW'(WIDTH) : CW'(MUL_LAT);
                    divOp   <= isDiv;
                    quoNeg  <= aNeg ^ bNeg;
                    remNeg  <= aNeg;
                    divZero <= (src_b == '0);
                    srcAReg <= src_a;
                end
                ST_BUSY: begin
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Product enters stage 0 at issue and reaches the last stage on the final BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++)
                mulPipe[i] <= '0;
        end else begin
            if (issue)
                mulPipe[0] <= product;
            if (state == ST_BUSY)
                for (int i = 1; i < MUL_LAT; i++)
                    mulPipe[i] <= mulPipe[i-1];
        end
    end

    // Divide by zero bypasses the sign fix-up so signed and unsigned agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (lastStep) begin
            if (!divOp)
                {hi, lo} <= mulPipe[MUL_LAT-1];
            else if (divZero)
                {hi, lo} <= {srcAReg, {WIDTH{1'b1}}};
            else
                {hi, lo} <= {remFix, quoFix};
        end
    end

endmodule
